// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the uart_tx serializer.
interface uart_tx_if #(
  parameter int unsigned INPUT_DATA_WIDTH = 8
);
  logic [INPUT_DATA_WIDTH-1:0] i_data;
  logic                        i_valid;
  logic                        o_ready;
  logic                        o_busy;

  modport master (output i_data, i_valid, input o_ready, o_busy);
  modport slave  (input i_data, i_valid, output o_ready, o_busy);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// Define TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module uart_tx #(
  parameter int unsigned INPUT_DATA_WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      baud_clk,
  uart_tx_if.slave  bus,
  output logic      serial_out
);

  localparam int unsigned IDX_W = $clog2(INPUT_DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
`ifdef TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t                      state_q, state_n;
  logic [IDX_W-1:0]            idx_q, idx_n;
  logic [INPUT_DATA_WIDTH-1:0] shreg_q, shreg_n;
  logic                        ready_q, ready_n;
  logic                        busy_q;
  logic                        line_q, line_n;
`ifdef TX_PARITY_EN
  logic                        par_q, par_n;
`endif

  // State and registered outputs; busy is kept as the exact complement of ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      line_q  <= 1'b1;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      shreg_q <= shreg_n;
      ready_q <= ready_n;
      busy_q  <= ~ready_n;
      line_q  <= line_n;
`ifdef TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  // Next state: acceptance ignores baud_clk, every later advance waits for a strobe.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    shreg_n = shreg_q;
    ready_n = ready_q;
    line_n  = line_q;
`ifdef TX_PARITY_EN
    par_n   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        line_n = 1'b1;
        if (bus.i_valid && ready_q) begin
          state_n = ST_WAIT;
          shreg_n = bus.i_data;
          ready_n = 1'b0;
`ifdef TX_PARITY_EN
          par_n   = ^bus.i_data;
`endif
        end
      end
      ST_WAIT: begin
        if (baud_clk) begin
          state_n = ST_START;
          line_n  = 1'b0;
        end
      end
      ST_START: begin
        if (baud_clk) begin
          state_n = ST_DATA;
          idx_n   = '0;
          line_n  = shreg_q[0];
          shreg_n = shreg_q >> 1;
        end
      end
      ST_DATA: begin
        if (baud_clk) begin
          if (idx_q < IDX_W'(INPUT_DATA_WIDTH - 1)) begin
            idx_n   = idx_q + IDX_W'(1);
            line_n  = shreg_q[0];
            shreg_n = shreg_q >> 1;
          end else begin
`ifdef TX_PARITY_EN
            state_n = ST_PARITY;
            line_n  = par_q;
`else
            state_n = ST_STOP;
            line_n  = 1'b1;
`endif
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (baud_clk) begin
          state_n = ST_STOP;
          line_n  = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_clk) begin
          state_n = ST_IDLE;
          ready_n = 1'b1;
          line_n  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
        line_n  = 1'b1;
      end
    endcase
  end

  assign bus.o_ready = ready_q;
  assign bus.o_busy  = busy_q;
  assign serial_out  = line_q;

endmodule
